// File: rtl/hazard_pkg.sv
// Shared types and default parameters for the multi-cycle-aware hazard unit.
package hazard_pkg;

    localparam int DEF_REG_W    = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_PERF_W   = 16;

    // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 7.
    localparam int LD_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MC_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side signal bundle of the hazard unit; slave is the hazard unit itself.
interface hazard_unit_mc_if
    import hazard_pkg::*;
#(
    parameter int REG_W  = DEF_REG_W,
    parameter int PERF_W = DEF_PERF_W
);

    logic [REG_W-1:0]  i_id_rs1;
    logic [REG_W-1:0]  i_id_rs2;
    logic              i_id_rs1_used;
    logic              i_id_rs2_used;
    logic [REG_W-1:0]  i_ex_rd;
    logic              i_ex_mem_read;
    logic              i_ex_mc_start;
    logic              i_mc_done;
    logic              i_ex_branch_taken;

    logic              o_pc_enable;
    logic              o_if_id_enable;
    logic              o_id_ex_enable;
    logic              o_id_ex_bubble;
    logic              o_if_id_flush;
    logic [PERF_W-1:0] o_stall_count;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_ex_rd, i_ex_mem_read, i_ex_mc_start, i_mc_done, i_ex_branch_taken,
        input  o_pc_enable, o_if_id_enable, o_id_ex_enable,
               o_id_ex_bubble, o_if_id_flush, o_stall_count
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_ex_rd, i_ex_mem_read, i_ex_mc_start, i_mc_done, i_ex_branch_taken,
        output o_pc_enable, o_if_id_enable, o_id_ex_enable,
               o_id_ex_bubble, o_if_id_flush, o_stall_count
    );

endinterface

// File: rtl/hazard_match.sv
// Combinational load-use detector: EX load writing a register the ID instruction reads.
module hazard_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_used && (rs1 == ex_rd);
    assign rs2_hit = rs2_used && (rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard control: branch flush, load-use stall of LOAD_LAT cycles, multi-cycle op wait.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int PERF_W   = DEF_PERF_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hazard_unit_mc_if.slave  bus
);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
            $error("hazard_unit_mc: LOAD_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [LD_CNT_W-1:0] LD_RELOAD = LD_CNT_W'(LOAD_LAT - 1);

    state_e              state_q, state_d;
    logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [PERF_W-1:0]   stall_cnt_q;
    logic                load_use;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic bubble;
    logic flush;

    hazard_match #(.REG_W(REG_W)) u_match (
        .rs1         (bus.i_id_rs1),
        .rs2         (bus.i_id_rs2),
        .rs1_used    (bus.i_id_rs1_used),
        .rs2_used    (bus.i_id_rs2_used),
        .ex_rd       (bus.i_ex_rd),
        .ex_mem_read (bus.i_ex_mem_read),
        .load_use    (load_use)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;

        if (!i_rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_ex_branch_taken) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        bubble   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d  = ST_LD_STALL;
                            ld_cnt_d = LD_RELOAD;
                        end
                    end else if (bus.i_ex_mc_start) begin
                        state_d = ST_MC_WAIT;
                    end
                end

                ST_LD_STALL: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                    ld_cnt_d = ld_cnt_q - 1'b1;
                    if (ld_cnt_q == LD_CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_MC_WAIT: begin
                    // Freeze the front of the pipe, including ID/EX, until the unit reports done.
                    if (bus.i_mc_done) begin
                        state_d = ST_IDLE;
                    end else begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        bubble   = 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ld_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            if (!pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_pc_enable    = pc_en;
    assign bus.o_if_id_enable = if_id_en;
    assign bus.o_id_ex_enable = id_ex_en;
    assign bus.o_id_ex_bubble = bubble;
    assign bus.o_if_id_flush  = flush;
    // Report zero for the whole reset cycle, not just after the clearing edge.
    assign bus.o_stall_count  = i_rst ? '0 : stall_cnt_q;

endmodule
